// File: rtl/cpu_pkg.sv
// Shared execute-stage types: ALU opcodes, exception codes, iterative-unit state/kind enums.
// EX_STAGE_DIV_EN decides whether DIVU/REMU count as iterative (divider present) or undefined.
package cpu_pkg;

  localparam int ALU_OP_BITS = 5;
  localparam int EXP_BITS    = 3;

  localparam logic [ALU_OP_BITS-1:0] ALU_OP_NOP   = 5'd0;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_AND   = 5'd1;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_OR    = 5'd2;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_XOR   = 5'd3;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_ADD   = 5'd4;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_SUB   = 5'd5;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_SHL   = 5'd6;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_SHR   = 5'd7;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_MUL   = 5'd8;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_MULHU = 5'd9;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_DIVU  = 5'd10;
  localparam logic [ALU_OP_BITS-1:0] ALU_OP_REMU  = 5'd11;

  localparam logic [EXP_BITS-1:0] EXP_NONE       = 3'd0;
  localparam logic [EXP_BITS-1:0] EXP_OVERFLOW   = 3'd1;
  localparam logic [EXP_BITS-1:0] EXP_DIV_ZERO   = 3'd2;
  localparam logic [EXP_BITS-1:0] EXP_UNDEF_INSN = 3'd3;

  typedef enum logic {ST_IDLE, ST_RUN} iter_state_t;
  typedef enum logic [1:0] {IK_MUL, IK_MULHU, IK_DIVU, IK_REMU} iter_kind_t;

  function automatic logic is_div_op(input logic [ALU_OP_BITS-1:0] op);
    return (op == ALU_OP_DIVU) || (op == ALU_OP_REMU);
  endfunction

  function automatic logic is_iterative(input logic [ALU_OP_BITS-1:0] op);
    case (op)
      ALU_OP_MUL, ALU_OP_MULHU: return 1'b1;
`ifdef EX_STAGE_DIV_EN
      ALU_OP_DIVU, ALU_OP_REMU: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic iter_kind_t iter_kind(input logic [ALU_OP_BITS-1:0] op);
    case (op)
      ALU_OP_MULHU: return IK_MULHU;
      ALU_OP_DIVU:  return IK_DIVU;
      ALU_OP_REMU:  return IK_REMU;
      default:      return IK_MUL;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Single-cycle ALU: logic, add/sub with signed overflow flag, logical shifts; purely combinational.
// Latency 0 (registered by the EX stage); no flow control of its own.
module alu
  import cpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ALU_OP_W = 5
) (
  input  logic [ALU_OP_W-1:0] op,
  input  logic [DATA_W-1:0]   in0,
  input  logic [DATA_W-1:0]   in1,
  output logic [DATA_W-1:0]   out,
  output logic                of
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic [SH_W-1:0]   shamt;

  assign sum   = in0 + in1;
  assign diff  = in0 - in1;
  assign shamt = in1[SH_W-1:0];

  always_comb begin
    out = '0;
    of  = 1'b0;
    case (ALU_OP_BITS'(op))
      ALU_OP_NOP: out = in0;
      ALU_OP_AND: out = in0 & in1;
      ALU_OP_OR:  out = in0 | in1;
      ALU_OP_XOR: out = in0 ^ in1;
      ALU_OP_ADD: begin
        out = sum;
        of  = (in0[MSB] == in1[MSB]) && (sum[MSB] != in0[MSB]);
      end
      ALU_OP_SUB: begin
        out = diff;
        of  = (in0[MSB] != in1[MSB]) && (diff[MSB] != in0[MSB]);
      end
      ALU_OP_SHL: out = in0 << shamt;
      ALU_OP_SHR: out = in0 >> shamt;
      default:    out = '0;
    endcase
  end

endmodule

// File: rtl/alu_iter.sv
// Iterative MUL/MULHU (shift-add) and, with EX_STAGE_DIV_EN, DIVU/REMU (restoring); one bit per cycle.
// Latency DATA_W+1 edges from issue; stall freezes the step, abort returns to IDLE at once.
module alu_iter
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              req,
  input  logic              abort,
  input  logic              stall,
  input  iter_kind_t        kind,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              div_zero
);

  localparam int CNT_W = $clog2(DATA_W);

  iter_state_t       state, state_nxt;
  iter_kind_t        kind_q, kind_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [DATA_W-1:0] hi, hi_nxt;
  logic [DATA_W-1:0] lo, lo_nxt;
  logic [DATA_W-1:0] opb, opb_nxt;
  logic [DATA_W-1:0] hi_step, lo_step;
  logic [DATA_W:0]   mul_sum;
  logic              last;

  assign last     = (state == ST_RUN) && (cnt == '0);
  assign busy     = !abort && (((state == ST_IDLE) && req) || ((state == ST_RUN) && (cnt != '0)));
  assign done     = last && !stall && !abort;
  assign div_zero = ((kind_q == IK_DIVU) || (kind_q == IK_REMU)) && (opb == '0);

  // {hi,lo} shifts right each step; multiplier bits leave through lo[0]
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(DATA_W+1){1'b0}});

`ifdef EX_STAGE_DIV_EN
  logic [DATA_W:0] div_shift;
  logic [DATA_W:0] div_diff;
  logic            div_take;

  assign div_shift = {hi, lo[DATA_W-1]};
  assign div_diff  = div_shift - {1'b0, opb};
  // a zero divisor always "fits", giving an all-ones quotient and the dividend as remainder
  assign div_take  = !div_diff[DATA_W] || (opb == '0);

  always_comb begin
    hi_step = mul_sum[DATA_W:1];
    lo_step = {mul_sum[0], lo[DATA_W-1:1]};
    if ((kind_q == IK_DIVU) || (kind_q == IK_REMU)) begin
      hi_step = div_take ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
      lo_step = {lo[DATA_W-2:0], div_take};
    end
  end
`else
  assign hi_step = mul_sum[DATA_W:1];
  assign lo_step = {mul_sum[0], lo[DATA_W-1:1]};
`endif

  always_comb begin
    case (kind_q)
      IK_MUL:   result = lo_step;
      IK_MULHU: result = hi_step;
      IK_DIVU:  result = lo_step;
      default:  result = hi_step;
    endcase
  end

  always_comb begin
    state_nxt = state;
    kind_nxt  = kind_q;
    cnt_nxt   = cnt;
    hi_nxt    = hi;
    lo_nxt    = lo;
    opb_nxt   = opb;
    if (abort) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end else if (!stall) begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state_nxt = ST_RUN;
            kind_nxt  = kind;
            cnt_nxt   = CNT_W'(DATA_W - 1);
            hi_nxt    = '0;
            lo_nxt    = a;
            opb_nxt   = b;
          end
        end
        ST_RUN: begin
          hi_nxt = hi_step;
          lo_nxt = lo_step;
          if (last) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt - 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state  <= ST_IDLE;
      kind_q <= IK_MUL;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
      opb    <= '0;
    end else begin
      state  <= state_nxt;
      kind_q <= kind_nxt;
      cnt    <= cnt_nxt;
      hi     <= hi_nxt;
      lo     <= lo_nxt;
      opb    <= opb_nxt;
    end
  end

endmodule

// File: rtl/ex_stage_mc.sv
// Execute stage: single-cycle ALU (1 clk) plus iterative mul/div (DATA_W+1 clks); EX_STAGE_DIV_EN enables DIVU/REMU.
// ExBusy holds ID while an iterative op runs; Flush/IntDetect beat Stall, Stall holds every register.
module ex_stage_mc
  import cpu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int ALU_OP_W   = 5,
  parameter int EXP_W      = 3,
  parameter int SIDE_W     = 64
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  IntDetect,
  input  logic                  IDEn,
  input  logic [ALU_OP_W-1:0]   IDALUOp,
  input  logic [DATA_W-1:0]     IDALUIn0,
  input  logic [DATA_W-1:0]     IDALUIn1,
  input  logic                  IDGPRWE_,
  input  logic [REG_ADDR_W-1:0] IDDstAddr,
  input  logic [EXP_W-1:0]      IDExpCode,
  input  logic [SIDE_W-1:0]     IDSide,
  output logic                  ExBusy,
  output logic                  EXEn,
  output logic [DATA_W-1:0]     EXOut,
  output logic                  EXGPRWE_,
  output logic [REG_ADDR_W-1:0] EXDstAddr,
  output logic [EXP_W-1:0]      EXExpCode,
  output logic [SIDE_W-1:0]     EXSide
);

  logic [ALU_OP_BITS-1:0] op;
  logic                   kill;
  logic                   exc_in;
  logic                   undef_op;
  logic [DATA_W-1:0]      alu_out;
  logic                   alu_of;
  logic                   iter_req;
  logic                   iter_busy;
  logic                   iter_done;
  logic                   iter_div_zero;
  logic [DATA_W-1:0]      iter_result;
  logic [DATA_W-1:0]      out_nxt;
  logic                   we_nxt;
  logic [EXP_W-1:0]       exp_nxt;

  assign op       = ALU_OP_BITS'(IDALUOp);
  assign kill     = Flush | IntDetect;
  assign exc_in   = (IDExpCode != EXP_W'(EXP_NONE));
  assign iter_req = IDEn && !exc_in && is_iterative(op);
  assign ExBusy   = iter_busy;

`ifdef EX_STAGE_DIV_EN
  assign undef_op = 1'b0;
`else
  assign undef_op = is_div_op(op);
`endif

  alu #(
    .DATA_W   (DATA_W),
    .ALU_OP_W (ALU_OP_W)
  ) u_alu (
    .op  (IDALUOp),
    .in0 (IDALUIn0),
    .in1 (IDALUIn1),
    .out (alu_out),
    .of  (alu_of)
  );

  alu_iter #(
    .DATA_W (DATA_W)
  ) u_iter (
    .clk      (clk),
    .reset_   (reset_),
    .req      (iter_req),
    .abort    (kill),
    .stall    (Stall),
    .kind     (iter_kind(op)),
    .a        (IDALUIn0),
    .b        (IDALUIn1),
    .busy     (iter_busy),
    .done     (iter_done),
    .result   (iter_result),
    .div_zero (iter_div_zero)
  );

  // single-cycle result and exception priority: incoming code, undefined op, overflow
  always_comb begin
    out_nxt = alu_out;
    we_nxt  = IDGPRWE_;
    exp_nxt = EXP_W'(EXP_NONE);
    if (!IDEn) begin
      we_nxt = 1'b1;
    end else if (exc_in) begin
      exp_nxt = IDExpCode;
      we_nxt  = 1'b1;
    end else if (undef_op) begin
      out_nxt = '0;
      exp_nxt = EXP_W'(EXP_UNDEF_INSN);
      we_nxt  = 1'b1;
    end else if (alu_of) begin
      exp_nxt = EXP_W'(EXP_OVERFLOW);
      we_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      EXEn      <= 1'b0;
      EXOut     <= '0;
      EXGPRWE_  <= 1'b1;
      EXDstAddr <= '0;
      EXExpCode <= EXP_W'(EXP_NONE);
      EXSide    <= '0;
    end else if (kill) begin
      EXEn      <= 1'b0;
      EXGPRWE_  <= 1'b1;
      EXExpCode <= EXP_W'(EXP_NONE);
      EXSide    <= '0;
    end else if (!Stall) begin
      if (iter_busy) begin
        EXEn      <= 1'b0;
        EXGPRWE_  <= 1'b1;
        EXExpCode <= EXP_W'(EXP_NONE);
      end else if (iter_done) begin
        EXEn      <= 1'b1;
        EXOut     <= iter_result;
        EXGPRWE_  <= IDGPRWE_ | iter_div_zero;
        EXExpCode <= iter_div_zero ? EXP_W'(EXP_DIV_ZERO) : EXP_W'(EXP_NONE);
        EXDstAddr <= IDDstAddr;
        EXSide    <= IDSide;
      end else begin
        EXEn      <= IDEn;
        EXOut     <= out_nxt;
        EXGPRWE_  <= we_nxt;
        EXExpCode <= exp_nxt;
        EXDstAddr <= IDDstAddr;
        EXSide    <= IDSide;
      end
    end
  end

endmodule

// File: tb/tb_ex_stage_mc.sv
// Scoreboard bench for ex_stage_mc: directed ops push expected results, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_ex_stage_mc;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        Stall = 1'b0, Flush = 1'b0, IntDetect = 1'b0, IDEn = 1'b0;
  logic [4:0]  IDALUOp = '0;
  logic [31:0] IDALUIn0 = '0, IDALUIn1 = '0;
  logic        IDGPRWE_ = 1'b1;
  logic [4:0]  IDDstAddr = '0;
  logic [2:0]  IDExpCode = '0;
  logic [63:0] IDSide = '0;
  logic        ExBusy, EXEn, EXGPRWE_;
  logic [31:0] EXOut;
  logic [4:0]  EXDstAddr;
  logic [2:0]  EXExpCode;
  logic [63:0] EXSide;

  ex_stage_mc #(.DATA_W(32), .REG_ADDR_W(5), .ALU_OP_W(5), .EXP_W(3), .SIDE_W(64)) dut (
    .clk(clk), .reset_(reset_), .Stall(Stall), .Flush(Flush), .IntDetect(IntDetect),
    .IDEn(IDEn), .IDALUOp(IDALUOp), .IDALUIn0(IDALUIn0), .IDALUIn1(IDALUIn1),
    .IDGPRWE_(IDGPRWE_), .IDDstAddr(IDDstAddr), .IDExpCode(IDExpCode), .IDSide(IDSide),
    .ExBusy(ExBusy), .EXEn(EXEn), .EXOut(EXOut), .EXGPRWE_(EXGPRWE_),
    .EXDstAddr(EXDstAddr), .EXExpCode(EXExpCode), .EXSide(EXSide)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic [2:0]  code;
    logic        we;
    logic [4:0]  dst;
    logic [63:0] side;
    bit          chk_out;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0, passed = 0, cyc = 0, tag = 0;
  logic stall_q = 1'b0;

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    stall_q <= Stall;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // monitor: every freshly loaded valid EX register must match the oldest expectation
  always @(negedge clk) begin
    if (reset_ && EXEn && !stall_q) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", 64'(EXEn), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_out) chk("exout", 64'(EXOut), 64'(mon_e.out));
        chk("expcode", 64'(EXExpCode), 64'(mon_e.code));
        chk("gprwe_", 64'(EXGPRWE_), 64'(mon_e.we));
        chk("dstaddr", 64'(EXDstAddr), 64'(mon_e.dst));
        chk("side", EXSide, mon_e.side);
        chk("latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] exp_in, input logic [31:0] eout, input logic [2:0] ecode,
                        input logic ewe, input bit chk_o, input int lat, input int ebusy,
                        input int stall_at, input int stall_len, input int flush_at);
    int busy_cnt;
    bit fin;
    exp_t e;
    @(posedge clk); #1;
    Stall = 1'b0; Flush = 1'b0;
    tag++;
    IDEn = 1'b1; IDALUOp = op; IDALUIn0 = a; IDALUIn1 = b; IDGPRWE_ = 1'b0;
    IDDstAddr = 5'(tag); IDExpCode = exp_in;
    IDSide = {32'hC0DE0000 | 32'(tag), ~32'(tag)};
    if (flush_at < 0) begin
      e.out = eout; e.code = ecode; e.we = ewe; e.dst = IDDstAddr; e.side = IDSide;
      e.chk_out = chk_o; e.cyc = cyc + lat;
      sb.push_back(e);
    end
    busy_cnt = 0;
    fin = 1'b0;
    for (int i = 0; i < 200 && !fin; i++) begin
      @(negedge clk);
      if (!ExBusy) fin = 1'b1;
      else begin
        busy_cnt++;
        @(posedge clk); #1;
        Stall = (i + 1 >= stall_at) && (i + 1 < stall_at + stall_len);
        Flush = (i + 1 == flush_at);
        if (Flush) Stall = 1'b1;
      end
    end
    chk("busy_cycles", 64'(busy_cnt), 64'(ebusy));
    if (flush_at >= 0) begin
      @(posedge clk); #1;
      Flush = 1'b0; Stall = 1'b0; IDEn = 1'b0;
      @(negedge clk);
      chk("flush_exen", 64'(EXEn), 64'd0);
      chk("flush_side", EXSide, 64'd0);
    end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    IDEn = 1'b0; Stall = 1'b0; Flush = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_exen"}, 64'(EXEn), 64'd0);
    chk({pfx, "_exout"}, 64'(EXOut), 64'd0);
    chk({pfx, "_gprwe_"}, 64'(EXGPRWE_), 64'd1);
    chk({pfx, "_dst"}, 64'(EXDstAddr), 64'd0);
    chk({pfx, "_exp"}, 64'(EXExpCode), 64'(EXP_NONE));
    chk({pfx, "_side"}, EXSide, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 20000", cyc);
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    chk("rst_busy", 64'(ExBusy), 64'd0);
    reset_ = 1'b1;
    idle(2);

    // single-cycle ALU
    run_op(ALU_OP_ADD, 32'h7FFFFFFF, 32'h1, EXP_NONE, 32'h80000000, EXP_OVERFLOW, 1'b1, 1, 1, 0, 0, 0, -1);
    run_op(ALU_OP_SUB, 32'd5, 32'd7, EXP_NONE, 32'hFFFFFFFE, EXP_NONE, 1'b0, 1, 1, 0, 0, 0, -1);
    run_op(ALU_OP_AND, 32'hF0F01234, 32'h0FF0FF00, EXP_NONE, 32'h00F01200, EXP_NONE, 1'b0, 1, 1, 0, 0, 0, -1);
    run_op(ALU_OP_OR, 32'hF0000000, 32'h0000000F, EXP_NONE, 32'hF000000F, EXP_NONE, 1'b0, 1, 1, 0, 0, 0, -1);
    run_op(ALU_OP_XOR, 32'hAAAA5555, 32'hFFFF0000, EXP_NONE, 32'h55555555, EXP_NONE, 1'b0, 1, 1, 0, 0, 0, -1);
    run_op(ALU_OP_SHL, 32'h1, 32'd33, EXP_NONE, 32'h2, EXP_NONE, 1'b0, 1, 1, 0, 0, 0, -1);
    run_op(ALU_OP_SHR, 32'h80000000, 32'd4, EXP_NONE, 32'h08000000, EXP_NONE, 1'b0, 1, 1, 0, 0, 0, -1);
    run_op(ALU_OP_ADD, 32'd3, 32'd4, EXP_NONE, 32'd7, EXP_NONE, 1'b0, 1, 1, 0, 0, 0, -1);
    run_op(ALU_OP_SUB, 32'h80000000, 32'd1, EXP_NONE, 32'h7FFFFFFF, EXP_OVERFLOW, 1'b1, 1, 1, 0, 0, 0, -1);

    // incoming exceptions pass through and never start the iterative unit
    run_op(ALU_OP_ADD, 32'd1, 32'd1, EXP_UNDEF_INSN, 32'd0, EXP_UNDEF_INSN, 1'b1, 0, 1, 0, 0, 0, -1);
    run_op(ALU_OP_MUL, 32'd3, 32'd3, EXP_OVERFLOW, 32'd0, EXP_OVERFLOW, 1'b1, 0, 1, 0, 0, 0, -1);

    // iterative multiply
    run_op(ALU_OP_MUL, 32'h00010003, 32'h00020005, EXP_NONE, 32'h000B000F, EXP_NONE, 1'b0, 1, 33, 32, 0, 0, -1);
    run_op(ALU_OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, EXP_NONE, 32'hFFFFFFFE, EXP_NONE, 1'b0, 1, 33, 32, 0, 0, -1);

`ifdef EX_STAGE_DIV_EN
    run_op(ALU_OP_DIVU, 32'd100, 32'd7, EXP_NONE, 32'd14, EXP_NONE, 1'b0, 1, 33, 32, 0, 0, -1);
    run_op(ALU_OP_REMU, 32'd100, 32'd7, EXP_NONE, 32'd2, EXP_NONE, 1'b0, 1, 33, 32, 0, 0, -1);
    run_op(ALU_OP_DIVU, 32'd55, 32'd0, EXP_NONE, 32'hFFFFFFFF, EXP_DIV_ZERO, 1'b1, 1, 33, 32, 0, 0, -1);
    run_op(ALU_OP_REMU, 32'd123, 32'd0, EXP_NONE, 32'd123, EXP_DIV_ZERO, 1'b1, 1, 33, 32, 0, 0, -1);
    run_op(ALU_OP_DIVU, 32'd1000, 32'd10, EXP_NONE, 32'd100, EXP_NONE, 1'b0, 1, 38, 37, 10, 5, -1);
`else
    run_op(ALU_OP_DIVU, 32'd100, 32'd7, EXP_NONE, 32'd0, EXP_UNDEF_INSN, 1'b1, 1, 1, 0, 0, 0, -1);
    run_op(ALU_OP_REMU, 32'd100, 32'd7, EXP_NONE, 32'd0, EXP_UNDEF_INSN, 1'b1, 1, 1, 0, 0, 0, -1);
    run_op(ALU_OP_DIVU, 32'd55, 32'd0, EXP_NONE, 32'd0, EXP_UNDEF_INSN, 1'b1, 1, 1, 0, 0, 0, -1);
`endif

    // stall mid-run delays completion by the stall length
    run_op(ALU_OP_MUL, 32'd7, 32'd6, EXP_NONE, 32'd42, EXP_NONE, 1'b0, 1, 38, 37, 10, 5, -1);

    // flush (with stall) at run cycle 10 aborts; following ADD is normal
    run_op(ALU_OP_MUL, 32'd9, 32'd9, EXP_NONE, 32'd0, EXP_NONE, 1'b0, 0, 0, 10, 0, 0, 10);
    run_op(ALU_OP_ADD, 32'd1, 32'd2, EXP_NONE, 32'd3, EXP_NONE, 1'b0, 1, 1, 0, 0, 0, -1);

    // async reset in the middle of a multiply
    @(posedge clk); #1;
    tag++;
    IDEn = 1'b1; IDALUOp = ALU_OP_MUL; IDALUIn0 = 32'd5; IDALUIn1 = 32'd5;
    IDExpCode = EXP_NONE; IDDstAddr = 5'(tag); IDSide = 64'hFEED;
    repeat (10) @(posedge clk);
    #2;
    reset_ = 1'b0;
    #1;
    chk_reset_vals("midrst");
    IDEn = 1'b0;
    @(posedge clk); #1;
    reset_ = 1'b1;
    @(negedge clk);
    chk("midrst_busy", 64'(ExBusy), 64'd0);
    run_op(ALU_OP_ADD, 32'd10, 32'd20, EXP_NONE, 32'd30, EXP_NONE, 1'b0, 1, 1, 0, 0, 0, -1);

    idle(5);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ex_stage_mc.md
Name: ex_stage_mc

Overview:
- Parametrised execute stage for the AZProcessor pipeline, sitting between ID and MEM.
- Keeps the single-cycle ALU path.
- Adds an iterative multiply/divide unit that holds the front of the pipe with ExBusy while it runs.
- All ID control sideband (PC, MemOp, MemWrData, CtrlOp, BrFlag) travels as one SIDE_W vector, so the stage is reusable across ISA variants.

Parameters:
- DATA_W, 32, datapath width (ALU operands, results). Must be ≥4 and a power of 2.
- REG_ADDR_W, 5, GPR address width.
- ALU_OP_W, 5, ALU opcode width.
- EXP_W, 3, exception code width.
- SIDE_W, 64, width of the pass-through control sideband.

Ports:
- clk  in  1  clock
- reset_  in  1  asynchronous active-low reset
- Stall  in  1  global hold from hazard controller
- Flush  in  1  kill the instruction entering EX; abort any running iterative op
- IntDetect  in  1  interrupt taken; treated exactly as Flush
- IDEn  in  1  ID instruction valid
- IDALUOp  in  ALU_OP_W  operation
- IDALUIn0  in  DATA_W  operand A
- IDALUIn1  in  DATA_W  operand B
- IDGPRWE_  in  1  register write enable, active low
- IDDstAddr  in  REG_ADDR_W  destination register
- IDExpCode  in  EXP_W  exception code from earlier stages
- IDSide  in  SIDE_W  opaque control sideband
- ExBusy  out  1  combinational; iterative op in flight, ID must hold
- EXEn  out  1  EX register valid
- EXOut  out  DATA_W  result
- EXGPRWE_  out  1  write enable, active low
- EXDstAddr  out  REG_ADDR_W  destination
- EXExpCode  out  EXP_W  exception code
- EXSide  out  SIDE_W  registered sideband

Behaviour:
- Reset (async, reset_=0): EXEn=0, EXOut=0, EXGPRWE_=1, EXDstAddr=0, EXExpCode=EXP_NONE, EXSide=0, FSM=IDLE, counter=0.
- Single-cycle ops (AND, OR, XOR, ADD, SUB, SHL, SHR, NOP) behave as follows:
  - Result appears on EXOut one clk after issue.
  - ADD/SUB signed overflow sets EXExpCode=EXP_OVERFLOW and forces EXGPRWE_=1.
  - Shifts use the low log2(DATA_W) bits of In1.
- Iterative ops: MUL (low DATA_W bits of the product), MULHU (high half, unsigned), DIVU, REMU.
- FSM states: IDLE and RUN.
  - IDLE→RUN when IDEn, the op is iterative, and Stall=0, Flush=0, IntDetect=0. Operands are latched and the counter loads DATA_W-1.
  - In RUN, each non-stalled cycle performs one shift-add (multiply) or restoring-subtract (divide) step, then decrements the counter.
  - RUN→IDLE on the step where counter==0.
- ExBusy=1 in the IDLE issue cycle of an iterative op and in every RUN cycle except the final one (counter==0).
- Issue to result: the EX register loads the iterative result on the final RUN edge. EXOut is therefore valid DATA_W+1 clocks after the issue edge.
- While ExBusy=1 and Stall=0, the EX register loads a bubble: EXEn=0, EXGPRWE_=1, EXExpCode=EXP_NONE. IDSide/IDDstAddr are held by ID and recaptured on the final edge.
- Divide by zero (In1=0) completes in the normal DATA_W+1 cycles:
  - DIVU result is all-ones; REMU result is In0.
  - EXExpCode=EXP_DIV_ZERO and EXGPRWE_=1.
- Precedence per edge:
  1. Flush or IntDetect: load a bubble, EXSide=0, FSM→IDLE, counter=0. This aborts RUN immediately.
  2. Stall: hold all registers, FSM and counter.
  3. Normal update.
- Flush and Stall asserted together: Flush wins.
- Incoming exceptions: IDEn=1 with IDExpCode≠EXP_NONE passes the code through, forces EXGPRWE_=1, and never starts the FSM.
- Reset asserted mid-RUN: immediate return to reset values; no partial result ever appears.

Optional Feature:
- Macro: EX_STAGE_DIV_EN.
- Defined: DIVU/REMU are implemented as described above.
- Undefined:
  - The divider datapath is removed.
  - DIVU/REMU complete in one cycle with EXOut=0, EXExpCode=EXP_UNDEF_INSN, EXGPRWE_=1.
  - ExBusy is never raised for them.
  - MUL/MULHU are unaffected.

Decomposition:
- Shared package cpu_pkg holds:
  - ALU opcode constants: ALU_OP_AND … ALU_OP_REMU.
  - Exception codes: EXP_NONE, EXP_OVERFLOW, EXP_DIV_ZERO, EXP_UNDEF_INSN.
  - An is_iterative(op) function.
- One sub-module, alu_iter, contains the FSM, counter, operand/accumulator registers and the step logic. It has a start/abort/stall/done interface.
- The existing single-cycle ALU is instantiated unchanged.

Test Plan (DATA_W=32):
- ADD, In0=0x7FFFFFFF, In1=1 → next cycle EXOut=0x80000000, EXExpCode=EXP_OVERFLOW, EXGPRWE_=1.
- MUL, In0=0x0001_0003, In1=0x0002_0005:
  - ExBusy high for 32 cycles.
  - EXOut=0x000B_000F exactly 33 clocks after issue.
  - EXEn=0 on every intermediate cycle.
- MULHU, In0=In1=0xFFFFFFFF → EXOut=0xFFFFFFFE after 33 clocks. DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU, In1=0 → EXOut=0xFFFFFFFF, EXExpCode=EXP_DIV_ZERO. With EX_STAGE_DIV_EN undefined → one cycle later EXExpCode=EXP_UNDEF_INSN and ExBusy never asserted.
- DIVU issued, Stall held 5 cycles mid-RUN → completion delayed by exactly 5 clocks with the same result. Flush at RUN cycle 10 → ExBusy drops the same cycle, EXEn=0, and the next ADD completes normally.
- reset_ pulled low mid-MUL → all outputs at reset values asynchronously; after release, ExBusy=0 and FSM=IDLE.
